leaf_cluster_arb: RTL
=====================

// Module: leaf_cluster_arb
// PURPOSE
//  Parametrised N-leaf cluster interface between one BFT leaf port and NUM_LEAF page-level leaf cores.
//  Downstream: demuxes BFT packets to leaves by address field. Upstream: buffers each leaf's packets
//  in a per-channel FIFO and round-robin merges them onto the single 49-bit BFT port, honouring BFT
//  resend backpressure. Generalises fixed quad wrappers to any channel count, with buffering and arbitration.
// PARAMETERS
//  NUM_LEAF    4   number of leaf channels (>=2)
//  PW          49  packet width; bit PW-1 = valid, bits PW-2:0 = payload
//  ADDR_LSB    43  LSB of leaf-select field in packet; field width CH_W=$clog2(NUM_LEAF)
//  FIFO_DEPTH  4   per-channel upstream FIFO entries (power of 2, >=2)
// PORTS
//  clk                      in   1              cluster clock
//  reset                    in   1              async active-high reset
//  din_leaf_bft2interface   in   PW             packet from BFT
//  dout_leaf_interface2bft  out  PW             packet to BFT
//  resend                   in   1              BFT backpressure: hold current dout, no pop
//  ap_start                 in   1              start strobe from BFT side
//  leaf_din                 out  NUM_LEAF*PW    packed per-leaf packets to leaves (ch i = [i*PW +: PW])
//  leaf_dout                in   NUM_LEAF*PW    packed per-leaf packets from leaves
//  leaf_resend              out  NUM_LEAF       per-leaf backpressure (FIFO full)
//  leaf_ap_start            out  NUM_LEAF       ap_start broadcast to every leaf
//  addr_err                 out  1              sticky: packet addressed to nonexistent leaf
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, FIFOs empty, rr pointer 0, addr_err 0.
//  Downstream demux, latency 1: if din[PW-1]=1, ch=din[ADDR_LSB +: CH_W]; next cycle leaf_din[ch]=din,
//   all other leaf_din=0. din valid=0 -> all leaf_din=0 next cycle. Packets are never buffered/stalled.
//  ch>=NUM_LEAF (non-pow2 NUM_LEAF): packet dropped, addr_err set, stays 1 until reset.
//  leaf_ap_start = {NUM_LEAF{ap_start}} registered, latency 1.
//  Upstream FIFO i: push when leaf_dout[i] valid bit=1 and count_i<FIFO_DEPTH; full packet stored.
//   leaf_resend[i] = (count_i==FIFO_DEPTH), combinational from registered count.
//   Packet presented while full is NOT accepted; leaf must hold/re-present it while leaf_resend[i]=1.
//   Push and pop same cycle: both occur, count unchanged; full still blocks push that cycle.
//  Arbiter (round robin): each cycle with resend=0, grant = first non-empty FIFO searching from rr_ptr
//   upward with wrap; popped packet drives dout next cycle (latency 1 from arbitration); rr_ptr<=grant+1 mod NUM_LEAF.
//   No FIFO non-empty and resend=0 -> dout=0 next cycle; rr_ptr unchanged.
//  resend=1: dout holds its value, no pop, rr_ptr unchanged; FIFOs still accept pushes.
//  resend held with dout=0 is legal (holds 0). Min latency leaf push -> dout: 2 cycles (write, then pop).
//  Ordering: per-channel FIFO order preserved; no packet lost or duplicated across resend windows.
//  Reset mid-traffic: all buffered packets discarded, no partial packet emitted.
//  Throughput: 1 packet/cycle out while any FIFO non-empty and resend=0.
// TESTING
//  1 Demux: din valid, addr field=2, payload 0x1234 -> cycle+1 leaf_din[2]=din, leaf_din[0,1,3]=0.
//  2 Round robin: ch0,1,3 each push 1 pkt same cycle -> dout order ch0,ch1,ch3 on 3 consecutive cycles, rr_ptr=0.
//  3 Full: ch1 pushes 5 pkts, resend=1 -> after 4 accepted leaf_resend[1]=1, 5th held; drop resend -> 5 pkts out in order.
//  4 Resend mid-stream: resend=1 for 3 cycles while dout=pktA -> dout stays pktA, pktB follows on release, no dup.
//  5 NUM_LEAF=3: din valid addr=3 -> no leaf_din valid, addr_err=1 and sticky until reset.
//  6 Reset with 2 pkts buffered in ch0 -> all outputs 0 immediately; after release dout=0, no stale packet.

Source files
------------

// File: rtl/leaf_cluster_arb.sv
// N-leaf cluster interface: demuxes BFT packets to leaf cores by address field and
// round-robin merges per-leaf upstream FIFOs onto the single BFT port.
module leaf_cluster_arb #(
  parameter int unsigned NUM_LEAF   = 4,
  parameter int unsigned PW         = 49,
  parameter int unsigned ADDR_LSB   = 43,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PW-1:0]          din_leaf_bft2interface,
  output logic [PW-1:0]          dout_leaf_interface2bft,
  input  logic                   resend,
  input  logic                   ap_start,
  output logic [NUM_LEAF*PW-1:0] leaf_din,
  input  logic [NUM_LEAF*PW-1:0] leaf_dout,
  output logic [NUM_LEAF-1:0]    leaf_resend,
  output logic [NUM_LEAF-1:0]    leaf_ap_start,
  output logic                   addr_err
);

  localparam int unsigned CH_W  = (NUM_LEAF > 1) ? $clog2(NUM_LEAF) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Downstream demux
  // ---------------------------------------------------------------------------
  logic                   dn_valid;
  logic [CH_W-1:0]        dn_ch;
  logic                   dn_bad;
  logic [NUM_LEAF*PW-1:0] leaf_din_d, leaf_din_q;
  logic [NUM_LEAF-1:0]    leaf_ap_start_q;
  logic                   addr_err_q;

  assign dn_valid = din_leaf_bft2interface[PW-1];
  assign dn_ch    = din_leaf_bft2interface[ADDR_LSB +: CH_W];
  // Only reachable when NUM_LEAF is not a power of two.
  assign dn_bad   = dn_valid && (32'(dn_ch) >= NUM_LEAF);

  always_comb begin
    leaf_din_d = '0;
    for (int unsigned i = 0; i < NUM_LEAF; i++) begin
      if (dn_valid && (32'(dn_ch) == i)) begin
        leaf_din_d[i*PW +: PW] = din_leaf_bft2interface;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel upstream FIFOs
  // ---------------------------------------------------------------------------
  logic [NUM_LEAF-1:0] push;
  logic [NUM_LEAF-1:0] pop;
  logic [NUM_LEAF-1:0] full;
  logic [NUM_LEAF-1:0] nonempty;
  logic [PW-1:0]       head [NUM_LEAF];
  logic [CH_W-1:0]     grant;
  logic                arb_go;

  for (genvar g = 0; g < NUM_LEAF; g++) begin : g_fifo
    logic [PW-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    assign full[g]     = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign nonempty[g] = (cnt_q != '0);
    // A full FIFO refuses the push even if it is popped in the same cycle.
    assign push[g]     = leaf_dout[g*PW + PW - 1] && !full[g];
    assign pop[g]      = arb_go && (grant == CH_W'(g));
    assign head[g]     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
      if (push[g]) begin
        mem_q[wr_ptr_q] <= leaf_dout[g*PW +: PW];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push[g]) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop[g])  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        unique case ({push[g], pop[g]})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign leaf_resend = full;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0] rr_d, rr_q;
  logic [CH_W-1:0] idx;
  logic            found;
  logic [PW-1:0]   dout_d, dout_q;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_LEAF; off++) begin
      idx = CH_W'((32'(rr_q) + off) % NUM_LEAF);
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign arb_go = !resend && found;

  always_comb begin
    dout_d = dout_q;
    rr_d   = rr_q;
    if (!resend) begin
      dout_d = found ? head[grant] : '0;
      if (found) begin
        rr_d = (32'(grant) + 1 == NUM_LEAF) ? '0 : grant + CH_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q          <= '0;
      rr_q            <= '0;
      leaf_din_q      <= '0;
      leaf_ap_start_q <= '0;
      addr_err_q      <= 1'b0;
    end else begin
      dout_q          <= dout_d;
      rr_q            <= rr_d;
      leaf_din_q      <= leaf_din_d;
      leaf_ap_start_q <= {NUM_LEAF{ap_start}};
      addr_err_q      <= addr_err_q | dn_bad;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign leaf_din                = leaf_din_q;
  assign leaf_ap_start           = leaf_ap_start_q;
  assign addr_err                = addr_err_q;

endmodule
